// File: rtl/aes_round_sched.sv
// Iterative AES round scheduler: steps one shared round datapath through Nr+1 rounds per block.
// Define AES_SCHED_ABORT_EN to add an abort input that cancels an in-flight block.
module aes_round_sched #(
  parameter int KEY_LENGTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [0:127]          in_block,
  input  logic [0:KEY_LENGTH-1] in_key,
  output logic [0:KEY_LENGTH-1] key_out,
  output logic [3:0]            rk_index,
  input  logic [0:127]          rk_in,
  output logic [0:127]          rnd_state,
  output logic [1:0]            rnd_kind,
  output logic                  rnd_dec,
  input  logic [0:127]          rnd_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          out_block,
`ifdef AES_SCHED_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy
);

  localparam int         NK      = KEY_LENGTH / 32;
  localparam int         NR      = NK + 6;
  localparam logic [3:0] NR4     = 4'(NR);
  localparam logic [3:0] LAST_RC = 4'(NR - 1);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              rc;
  logic [0:127]            state_reg;
  logic [0:KEY_LENGTH-1]   key_reg;
  logic                    mode_reg;
  logic                    accept;
  logic                    abort_hit;

  // rk_in feeds the external round datapath directly; the scheduler never consumes it.
  logic unused_rk;
  assign unused_rk = ^rk_in;

  assign accept = in_valid && in_ready;

`ifdef AES_SCHED_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = INIT;
      INIT:    state_nxt = ROUND;
      ROUND:   if (rc == LAST_RC) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // Round-key order runs forward for encrypt and backward for decrypt.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == INIT) || (state == ROUND) || (state == FINAL);
    rnd_kind = 2'b11;
    rk_index = 4'd0;
    case (state)
      INIT: begin
        rnd_kind = 2'b00;
        rk_index = mode_reg ? NR4 : 4'd0;
      end
      ROUND: begin
        rnd_kind = 2'b01;
        rk_index = mode_reg ? NR4 - rc : rc;
      end
      FINAL: begin
        rnd_kind = 2'b10;
        rk_index = mode_reg ? 4'd0 : NR4;
      end
      default: ;
    endcase
  end

  assign rnd_state = state_reg;
  assign key_out   = key_reg;
  assign rnd_dec   = mode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc        <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      mode_reg  <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
    end else if (abort_hit) begin
      rc <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state_reg <= in_block;
          key_reg   <= in_key;
          mode_reg  <= in_mode;
        end
        INIT: begin
          state_reg <= rnd_result;
          rc        <= 4'd1;
        end
        ROUND: begin
          state_reg <= rnd_result;
          if (rc != LAST_RC) rc <= rc + 4'd1;
        end
        FINAL: begin
          rc        <= '0;
          out_block <= rnd_result;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Scoreboard bench for aes_round_sched: AES-128 and AES-256 instances, each wrapped in
// a behavioural AES round datapath and key expansion; expected blocks are queued on acceptance.
module tb_aes_round_sched;

  typedef logic [0:14][0:127] rk_arr_t;
  typedef struct { logic [0:127] blk; int lat; } exp_t;

  localparam logic [0:127] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:255] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int           sel = 0;
  logic         in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [0:127] in_block = '0;
  logic [0:255] in_key = '0;
`ifdef AES_SCHED_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  // ---------------- AES reference primitives ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [0:127] mix_cols(input logic [0:127] s, input logic inv);
    logic [7:0] m [4];
    logic [7:0] acc;
    logic [0:127] r;
    r = '0;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int col = 0; col < 4; col++)
      for (int k = 0; k < 4; k++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - k + 4) % 4], s[8*(4*col + j) +: 8]);
        r[8*(4*col + k) +: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] rk,
                                            input logic [1:0] kind, input logic dec);
    logic [0:127] t;
    int src;
    if (kind == 2'b00) return s ^ rk;
    if (kind == 2'b11) return s;
    t = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) begin
        src = dec ? row + 4*((col + 4 - row) % 4) : row + 4*((col + row) % 4);
        t[8*(row + 4*col) +: 8] = dec ? inv_sbox[s[8*src +: 8]] : sbox[s[8*src +: 8]];
      end
    if (!dec) begin
      if (kind == 2'b01) t = mix_cols(t, 1'b0);
      return t ^ rk;
    end
    t = t ^ rk;
    if (kind == 2'b01) t = mix_cols(t, 1'b1);
    return t;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic rk_arr_t expand(input logic [0:255] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rk_arr_t     rks;
    rks  = '0;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic logic [0:127] ref_aes(input logic [0:127] blk, input logic [0:255] key,
                                          input int nk, input logic dec);
    rk_arr_t rks;
    logic [0:127] s;
    int nr;
    nr  = nk + 6;
    rks = expand(key, nk);
    s   = blk ^ rks[dec ? nr : 0];
    for (int r = 1; r < nr; r++) s = aes_round(s, rks[dec ? nr - r : r], 2'b01, dec);
    return aes_round(s, rks[dec ? 0 : nr], 2'b10, dec);
  endfunction

  // ---------------- DUT instances and their environments ----------------
  logic in_valid_a, in_valid_b;
  assign in_valid_a = in_valid && (sel == 0);
  assign in_valid_b = in_valid && (sel == 1);

  logic         in_ready_a, rnd_dec_a, out_valid_a, busy_a;
  logic [0:127] key_out_a, rk_in_a, rnd_state_a, rnd_result_a, out_block_a;
  logic [3:0]   rk_index_a;
  logic [1:0]   rnd_kind_a;
  rk_arr_t      rk_a;

  logic         in_ready_b, rnd_dec_b, out_valid_b, busy_b;
  logic [0:255] key_out_b;
  logic [0:127] rk_in_b, rnd_state_b, rnd_result_b, out_block_b;
  logic [3:0]   rk_index_b;
  logic [1:0]   rnd_kind_b;
  rk_arr_t      rk_b;

  aes_round_sched #(.KEY_LENGTH(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_mode(in_mode), .in_block(in_block), .in_key(in_key[0:127]), .key_out(key_out_a),
    .rk_index(rk_index_a), .rk_in(rk_in_a), .rnd_state(rnd_state_a), .rnd_kind(rnd_kind_a),
    .rnd_dec(rnd_dec_a), .rnd_result(rnd_result_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_block(out_block_a),
`ifdef AES_SCHED_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_a));

  aes_round_sched #(.KEY_LENGTH(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_mode(in_mode), .in_block(in_block), .in_key(in_key), .key_out(key_out_b),
    .rk_index(rk_index_b), .rk_in(rk_in_b), .rnd_state(rnd_state_b), .rnd_kind(rnd_kind_b),
    .rnd_dec(rnd_dec_b), .rnd_result(rnd_result_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_block(out_block_b),
`ifdef AES_SCHED_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_b));

  always_comb rk_a = expand({key_out_a, 128'h0}, 4);
  always_comb rk_in_a = rk_a[rk_index_a];
  always_comb rnd_result_a = aes_round(rnd_state_a, rk_in_a, rnd_kind_a, rnd_dec_a);
  always_comb rk_b = expand(key_out_b, 8);
  always_comb rk_in_b = rk_b[rk_index_b];
  always_comb rnd_result_b = aes_round(rnd_state_b, rk_in_b, rnd_kind_b, rnd_dec_b);

  // Observed view of whichever instance is selected.
  logic         in_ready, out_valid, busy, rnd_dec;
  logic [0:127] out_block, rnd_state;
  logic [0:255] key_out;
  logic [3:0]   rk_index;
  logic [1:0]   rnd_kind;
  always_comb begin
    if (sel == 1) begin
      in_ready = in_ready_b; out_valid = out_valid_b; busy = busy_b; rnd_dec = rnd_dec_b;
      out_block = out_block_b; rnd_state = rnd_state_b; key_out = key_out_b;
      rk_index = rk_index_b; rnd_kind = rnd_kind_b;
    end else begin
      in_ready = in_ready_a; out_valid = out_valid_a; busy = busy_a; rnd_dec = rnd_dec_a;
      out_block = out_block_a; rnd_state = rnd_state_a; key_out = {key_out_a, 128'h0};
      rk_index = rk_index_a; rnd_kind = rnd_kind_a;
    end
  end

  // ---------------- scoreboard and monitor ----------------
  int         checks = 0, errors = 0;
  int         cyc = 0, acc_cyc = 0, xfers = 0;
  logic       prev_valid = 1'b0;
  exp_t       sb [$];
  int         acc_log [$];
  logic [3:0] rk_log [$];
  logic [1:0] kind_log [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc + 1;
        acc_log.push_back(cyc + 1);
      end
      if (busy) begin
        rk_log.push_back(rk_index);
        kind_log.push_back(rnd_kind);
      end
      if (out_valid && !prev_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_out_valid: got out_valid=1 want no pending block");
        end else if (cyc - acc_cyc != sb[0].lat) begin
          errors++; $display("FAIL latency: got %0d edges want %0d", cyc - acc_cyc, sb[0].lat);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        xfers++;
        checks++;
        if (out_block !== e.blk) begin
          errors++; $display("FAIL out_block: got %h want %h", out_block, e.blk);
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus tasks (entered and left just after a rising edge) ----------------
  task automatic send(input logic mode, input logic [0:127] blk, input logic [0:255] key,
                      input logic [0:127] exp_blk, input int lat);
    int n;
    in_mode = mode; in_block = blk; in_key = key; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 300);
    checks++;
    if (!in_ready) begin
      errors++; $display("FAIL accept_timeout: got in_ready=0 want 1 within 300 cycles");
    end else begin
      sb.push_back('{exp_blk, lat});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_mode = ~mode; in_block = ~blk; in_key = ~key;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, rnd_kind, rk_index} !== 9'b1_0_0_11_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 100110000", {in_ready, out_valid, busy, rnd_kind, rk_index});
    end
    checks++;
    if ({out_block, rnd_state, key_out, rnd_dec} !== '0) begin
      errors++; $display("FAIL reset_data: got out_block=%h rnd_state=%h want zeros", out_block, rnd_state);
    end
    checks++;
    if ({in_ready_b, out_valid_b, busy_b, rnd_kind_b} !== 5'b1_0_0_11) begin
      errors++; $display("FAIL reset_b: got %b want 10011", {in_ready_b, out_valid_b, busy_b, rnd_kind_b});
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_enc128();
    logic ok;
    sel = 0; rk_log.delete(); kind_log.delete();
    send(1'b0, PT, {K128, 128'h0}, CT, 11);
    @(negedge clk);
    checks++;
    if (key_out !== {K128, 128'h0} || rnd_dec !== 1'b0) begin
      errors++; $display("FAIL enc_key_out: got %h want %h", key_out[0:127], K128);
    end
    @(posedge clk); #1;
    wait_drain();
    ok = (rk_log.size() == 11) && (kind_log.size() == 11);
    for (int i = 0; ok && i < 11; i++)
      if (rk_log[i] !== 4'(i) || kind_log[i] !== (i == 0 ? 2'b00 : i == 10 ? 2'b10 : 2'b01)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL enc_rk_sequence: got %0d entries, first rk %0d, want 0..10 with kinds 0,1x9,2",
                         rk_log.size(), rk_log.size() ? rk_log[0] : 4'd0);
    end
  endtask

  task automatic test_dec128();
    logic ok;
    sel = 0; rk_log.delete();
    send(1'b1, CT, {K128, 128'h0}, PT, 11);
    wait_drain();
    ok = (rk_log.size() == 11);
    for (int i = 0; ok && i < 11; i++) if (rk_log[i] !== 4'(10 - i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL dec_rk_sequence: got %0d entries, first rk %0d, want 10 down to 0",
                         rk_log.size(), rk_log.size() ? rk_log[0] : 4'd0);
    end
  endtask

  task automatic test_dec256();
    logic ok;
    sel = 1; rk_log.delete();
    send(1'b1, CT256, K256, PT, 15);
    wait_drain();
    ok = (rk_log.size() == 15);
    for (int i = 0; ok && i < 15; i++) if (rk_log[i] !== 4'(14 - i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL dec256_rk_sequence: got %0d entries want 14 down to 0", rk_log.size());
    end
    sel = 0;
  endtask

  task automatic test_back_pressure();
    logic [0:127] held;
    int n, x0;
    sel = 0; out_ready = 1'b0; x0 = xfers;
    send(1'b0, PT, {K128, 128'h0}, CT, 11);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid) begin
      errors++; $display("FAIL bp_valid_timeout: got out_valid=0 want 1");
    end
    held = rnd_state;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = 1'b1; in_block = CT; in_key = ~in_key;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_block !== CT || in_ready !== 1'b0 || rnd_state !== held || key_out !== {K128, 128'h0}) begin
        errors++; $display("FAIL bp_hold: got valid=%b block=%h ready=%b want 1 %h 0", out_valid, out_block, in_ready, CT);
      end
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (xfers - x0 !== 1) begin
      errors++; $display("FAIL bp_transfers: got %0d want 1", xfers - x0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [0:127] blk, ct;
    logic [0:255] key;
    sel = 0; acc_log.delete();
    for (int i = 0; i < 2; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      ct  = ref_aes(blk, key, 4, 1'b0);
      send(1'b0, blk, key, ct, 11);
      send(1'b1, ct, key, blk, 11);
    end
    wait_drain();
    checks++;
    if (acc_log.size() != 4) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 4", acc_log.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_log[i] - acc_log[i-1] != 13) begin
          errors++; $display("FAIL b2b_spacing: got %0d cycles want 13", acc_log[i] - acc_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 0;
    send(1'b1, CT, {K128, 128'h0}, PT, 11);
    n = 0;
    do begin @(negedge clk); n++; end while (!(rnd_kind == 2'b01 && rk_index == 4'd5) && n < 50);
    checks++;
    if (rnd_kind !== 2'b01 || rk_index !== 4'd5) begin
      errors++; $display("FAIL rm_reach_round: got kind=%b rk=%0d want 01 5", rnd_kind, rk_index);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, rnd_kind, rk_index} !== 9'b1_0_0_11_0000) begin
      errors++; $display("FAIL rm_ctrl: got %b want 100110000", {in_ready, out_valid, busy, rnd_kind, rk_index});
    end
    checks++;
    if ({out_block, rnd_state, key_out, rnd_dec} !== '0) begin
      errors++; $display("FAIL rm_data: got out_block=%h rnd_state=%h dec=%b want zeros", out_block, rnd_state, rnd_dec);
    end
    sb.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rm_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    send(1'b0, PT, {K128, 128'h0}, CT, 11);
    wait_drain();
  endtask

`ifdef AES_SCHED_ABORT_EN
  task automatic test_abort();
    logic [0:127] last;
    int n;
    sel = 0; last = out_block;
    send(1'b0, CT, {K128, 128'h0}, PT, 11);
    n = 0;
    do begin @(negedge clk); n++; end while (rnd_kind != 2'b01 && n < 50);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checks++;
    if ({in_ready, busy, rnd_kind} !== 4'b1_0_11) begin
      errors++; $display("FAIL abort_idle: got %b want 1011", {in_ready, busy, rnd_kind});
    end
    sb.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_block !== last) begin
        errors++; $display("FAIL abort_quiet: got valid=%b block=%h want 0 %h", out_valid, out_block, last);
      end
    end
    @(posedge clk); #1;
    send(1'b0, PT, {K128, 128'h0}, CT, 11);
    wait_drain();
  endtask
`endif

  initial begin
    logic [7:0] inv, s;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
    test_reset();
    test_enc128();
    test_dec128();
    test_dec256();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_SCHED_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative round scheduler for the AES core. It accepts a 128-bit block and key over a valid/ready handshake and latches the mode (encrypt or decrypt). It then steps one shared single-round datapath through the initial AddRoundKey, Nr−1 middle rounds and the final round, one round per clock. It sits between the Nios V CSR front end and the round/key-expansion logic, so a single round instance replaces the fully unrolled Nr-round chain.

## Interface
- KEY_LENGTH, 128, key width: 128, 192 or 256. Nk = KEY_LENGTH/32; Nr = Nk+6.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request carries a valid block and key.
- in_ready  out  1  scheduler can accept a request.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_block  in  [0:127]  plaintext or ciphertext.
- in_key  in  [0:KEY_LENGTH-1]  cipher key.
- key_out  out  [0:KEY_LENGTH-1]  latched key, drives external key expansion.
- rk_index  out  4  round-key index requested from key expansion.
- rk_in  in  [0:127]  round key for rk_index (combinational return).
- rnd_state  out  [0:127]  current state into the round datapath.
- rnd_kind  out  2  00 = initial AddRoundKey, 01 = middle round, 10 = final round, 11 = idle.
- rnd_dec  out  1  latched mode, selects inverse round operations.
- rnd_result  in  [0:127]  round datapath output (combinational from rnd_state/rk_in/rnd_kind).
- out_valid  out  1  out_block is valid.
- out_ready  in  1  consumer accepts out_block.
- out_block  out  [0:127]  result block.
- busy  out  1  high in INIT, ROUND and FINAL.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- in_ready = (state == IDLE).
- Acceptance: the edge with in_valid && in_ready latches in_block into state_reg, in_key into key_reg and in_mode into mode_reg, then goes to INIT.
- INIT: rnd_kind = 00. Encrypt rk_index = 0; decrypt rk_index = Nr. state_reg ← rnd_result. Round counter rc ← 1. Next state is ROUND.
- ROUND: rnd_kind = 01. Encrypt rk_index = rc; decrypt rk_index = Nr−rc. state_reg ← rnd_result; rc ← rc+1. Leave for FINAL on the edge where rc == Nr−1.
- FINAL: rnd_kind = 10. Encrypt rk_index = Nr; decrypt rk_index = 0. out_block ← rnd_result; out_valid ← 1. Next state is DONE.
- DONE: out_valid and out_block are held stable while out_ready = 0. The edge with out_ready = 1 clears out_valid and returns to IDLE.
- In IDLE and DONE, rnd_kind = 11 and rk_index = 0.
- rc is 4 bits and never wraps. The maximum is Nr−1 = 13.
- in_valid in any state other than IDLE is ignored; nothing is latched.
- in_block, in_key and in_mode need to be stable only on the acceptance edge.
- Reset, including assertion mid-operation, forces:
  - state = IDLE, rc = 0, out_valid = 0, out_block = 0;
  - state_reg = 0, key_reg = 0, mode_reg = 0;
  - busy = 0, rk_index = 0, rnd_kind = 11.
  - Any in-flight block is discarded; no out_valid pulse is produced.

## Timing
- Latency: out_valid rises on the (Nr+1)th rising edge after the acceptance edge. That is 11, 13 or 15 edges for AES-128, AES-192 and AES-256.
- Throughput with out_ready tied high: one block every Nr+3 cycles. That is acceptance, Nr+1 processing edges, then the DONE→IDLE edge.
- rk_index, rnd_kind and rnd_state are registered-state decodes, valid for the whole cycle.
- The rk_in → rnd_result → state_reg path must close in one cycle.
- The out_valid/out_ready handshake follows the standard rule: a transfer occurs on the edge where both are high.

## Configuration
- AES_SCHED_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort = 1 in INIT, ROUND or FINAL returns the FSM to IDLE on the next edge and clears rc and busy.
  - out_valid stays 0 and out_block keeps its previous value.
  - abort in IDLE or DONE has no effect; DONE still waits for out_ready.
- AES_SCHED_ABORT_EN undefined: the port is absent and every accepted block runs to completion.

## Test plan
- Encrypt, AES-128: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, mode 0.
  - out_valid rises 11 edges after acceptance.
  - out_block = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt, AES-128: same key, block 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1.
  - out_block = 00112233445566778899aabbccddeeff.
  - rk_index sequence is 10, 9, …, 1, 0.
- Decrypt, AES-256 (KEY_LENGTH = 256): key 000102…1e1f, block 8ea2b7ca516745bfeafc49904b496089.
  - out_block = 00112233445566778899aabbccddeeff after 15 edges.
- Back-pressure: hold out_ready = 0 for 20 cycles after out_valid.
  - out_block is stable, in_ready = 0 and a second in_valid is ignored.
  - Raising out_ready then gives exactly one transfer, and in_ready = 1 on the next cycle.
- Reset mid-round: assert rst_n = 0 asynchronously during ROUND (rc = 5).
  - All outputs go immediately to their reset values.
  - After release, in_ready = 1 and a fresh AES-128 encrypt gives the correct ciphertext.
- Abort (AES_SCHED_ABORT_EN): pulse abort in ROUND.
  - The FSM is IDLE on the next edge, out_valid never rises, and a subsequent request completes correctly.
